// File: rtl/lpc_host_io.sv
// LPC host engine: issues single I/O read/write cycles to an LPC target,
// tracking target wait states and driving the abort sequence on error/timeout.
module lpc_host_io #(
  parameter int SYNC_TIMEOUT  = 8,
  parameter int LONG_WAIT_MAX = 255
) (
  input  logic        LpcClock,
  input  logic        PciReset,
  input  logic        Req,
  input  logic        Write,
  input  logic [15:0] Addr,
  input  logic [7:0]  WrData,
  output logic [7:0]  RdData,
  output logic        Busy,
  output logic        Done,
  output logic        Err,
  output logic        LpcFrame,
  inout  wire  [3:0]  LpcBus
);

  localparam int LMAX =
    (LONG_WAIT_MAX > SYNC_TIMEOUT) ? LONG_WAIT_MAX : SYNC_TIMEOUT;
  localparam int CW = $clog2(LMAX + 1) + 1;
  localparam logic [CW-1:0] LIM_S = CW'(SYNC_TIMEOUT);
  localparam logic [CW-1:0] LIM_L = CW'(LONG_WAIT_MAX);

  typedef enum logic [4:0] {
    S_IDLE, S_START, S_CYC, S_ADDR3, S_ADDR2, S_ADDR1, S_ADDR0,
    S_WDATA0, S_WDATA1, S_TAR0, S_TAR1, S_SYNC, S_RDATA0, S_RDATA1,
    S_TAR2, S_TAR3, S_DONE, S_ABORT, S_ABORT_END
  } state_e;

  state_e        state_q, state_d;
  logic          wr_q, wr_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          long_q, long_d;
  logic [1:0]    abc_q, abc_d;
  logic          fail_q, fail_d;
  logic [3:0]    rdlo_q, rdlo_d;
  logic [7:0]    rd_q, rd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          frame_q, frame_d;
  logic          oe_q, oe_d;
  logic [3:0]    lad_q, lad_d;

  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      long_q  <= 1'b0;
      abc_q   <= '0;
      fail_q  <= 1'b0;
      rdlo_q  <= '0;
      rd_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      frame_q <= 1'b1;
      oe_q    <= 1'b0;
      lad_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      long_q  <= long_d;
      abc_q   <= abc_d;
      fail_q  <= fail_d;
      rdlo_q  <= rdlo_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      frame_q <= frame_d;
      oe_q    <= oe_d;
      lad_q   <= lad_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    long_d  = long_q;
    abc_d   = abc_q;
    fail_d  = fail_q;
    rdlo_d  = rdlo_q;
    rd_d    = rd_q;
    unique case (state_q)
      S_IDLE: begin
        if (Req) begin
          state_d = S_START;
          wr_d    = Write;
          addr_d  = Addr;
          wdata_d = WrData;
          cnt_d   = '0;
          long_d  = 1'b0;
          fail_d  = 1'b0;
        end
      end
      S_START:  state_d = S_CYC;
      S_CYC:    state_d = S_ADDR3;
      S_ADDR3:  state_d = S_ADDR2;
      S_ADDR2:  state_d = S_ADDR1;
      S_ADDR1:  state_d = S_ADDR0;
      S_ADDR0:  state_d = wr_q ? S_WDATA0 : S_TAR0;
      S_WDATA0: state_d = S_WDATA1;
      S_WDATA1: state_d = S_TAR0;
      S_TAR0:   state_d = S_TAR1;
      S_TAR1:   state_d = S_SYNC;
      S_SYNC: begin
        unique case (1'b1)
          (LpcBus == 4'b0000): state_d = wr_q ? S_TAR2 : S_RDATA0;
          (LpcBus == 4'b1010): begin
            state_d = S_ABORT;
            fail_d  = 1'b1;
            abc_d   = '0;
          end
          default: begin
            cnt_d = cnt_q + CW'(1);
            if (LpcBus == 4'b0110) long_d = 1'b1;
            // once long wait is seen the whole SYNC run is judged on the long limit
            if (cnt_d >= (long_d ? LIM_L : LIM_S)) begin
              state_d = S_ABORT;
              fail_d  = 1'b1;
              abc_d   = '0;
            end
          end
        endcase
      end
      S_RDATA0: begin
        rdlo_d  = LpcBus;
        state_d = S_RDATA1;
      end
      S_RDATA1: begin
        rd_d    = {LpcBus, rdlo_q};
        state_d = S_TAR2;
      end
      S_TAR2:   state_d = S_TAR3;
      S_TAR3:   state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      S_ABORT: begin
        abc_d = abc_q + 2'd1;
        if (abc_q == 2'd3) state_d = S_ABORT_END;
      end
      S_ABORT_END: state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  // pins are registered, so decode them from the state being entered
  always_comb begin
    frame_d = 1'b1;
    oe_d    = 1'b0;
    lad_d   = 4'b0000;
    busy_d  = 1'b1;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_d)
      S_IDLE: busy_d = 1'b0;
      S_START: begin
        frame_d = 1'b0;
        oe_d    = 1'b1;
      end
      S_CYC: begin
        oe_d  = 1'b1;
        lad_d = {2'b00, wr_d, 1'b0};
      end
      S_ADDR3: begin
        oe_d  = 1'b1;
        lad_d = addr_d[15:12];
      end
      S_ADDR2: begin
        oe_d  = 1'b1;
        lad_d = addr_d[11:8];
      end
      S_ADDR1: begin
        oe_d  = 1'b1;
        lad_d = addr_d[7:4];
      end
      S_ADDR0: begin
        oe_d  = 1'b1;
        lad_d = addr_d[3:0];
      end
      S_WDATA0: begin
        oe_d  = 1'b1;
        lad_d = wdata_d[3:0];
      end
      S_WDATA1: begin
        oe_d  = 1'b1;
        lad_d = wdata_d[7:4];
      end
      S_TAR0: begin
        oe_d  = 1'b1;
        lad_d = 4'b1111;
      end
      S_ABORT: begin
        frame_d = 1'b0;
        oe_d    = 1'b1;
        lad_d   = 4'b1111;
      end
      S_DONE: begin
        busy_d = 1'b0;
        done_d = 1'b1;
        err_d  = fail_d;
      end
      default: ;
    endcase
  end

  assign LpcBus   = oe_q ? lad_q : 4'bzzzz;
  assign LpcFrame = frame_q;
  assign RdData   = rd_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Err      = err_q;

endmodule
